dot_host_ctrl: RTL and testbench
================================

// Module: dot_host_ctrl
// PURPOSE
//  Initiator side of the dot-product accelerator interface (sys_clk/ram_init/start_sig/n/a,b RAM load/result/done_flag).
//  Accepts a length command plus a valid/ready stream of (a,b) pairs, loads them into the accelerator RAMs,
//  pulses start_sig, waits for done_flag, returns result on a valid/ready response port.
//  Sits between the host/stream fabric and the accelerator top; replaces bench-driven RAM init and start.
// PARAMETERS
//  DATA_W       32    width of a/b elements, n and result
//  ADDR_W       16    RAM address width
//  DEPTH        1024  max accepted n (must be <= 2**ADDR_W)
//  TIMEOUT_CYC  4096  WAIT-state watchdog limit (used only with DOT_TIMEOUT_EN)
// PORTS
//  sys_clk    in   1       clock, all logic rising-edge
//  sys_rst    in   1       asynchronous reset, active-high
//  cmd_valid  in   1       command valid
//  cmd_ready  out  1       command accepted (high only in IDLE)
//  cmd_n      in   DATA_W  vector length for this command
//  in_valid   in   1       element pair valid
//  in_ready   out  1       element pair accepted (high only in LOAD)
//  in_a/in_b  in   DATA_W  element pair
//  ram_init   out  1       RAM write strobe to accelerator, one cycle per element
//  a_addr_in/b_addr_in  out  ADDR_W  write address (identical values)
//  a_ram_in/b_ram_in    out  DATA_W  write data
//  start_sig  out  1       one-cycle start pulse
//  n          out  DATA_W  length to accelerator, held from cmd accept until next cmd accept
//  result_in  in   DATA_W  accelerator result
//  done_in    in   1       accelerator done_flag (level)
//  res_valid  out  1       response valid
//  res_ready  in   1       response accepted
//  res_data   out  DATA_W  captured result (0 on error)
//  res_err    out  1       1 = n out of range or timeout
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_ready=1 one cycle after reset release); state IDLE; element counter 0.
//  Reset mid-operation: immediate return to IDLE, ram_init/start_sig drop same instant; pending data discarded.
//  FSM IDLE -> LOAD -> GAP -> START -> WAIT -> RESP -> IDLE.
//  IDLE: cmd_valid&cmd_ready latches cmd_n into n. n==0 -> RESP (res_data=0, res_err=0, no start pulse).
//        n>DEPTH -> RESP (res_err=1, res_data=0). else -> LOAD, cnt=0.
//  LOAD: in_ready=1. Handshake in cycle k -> cycle k+1: ram_init=1, addr=cnt, data=in_a/in_b; cnt++.
//        No handshake -> ram_init=0 next cycle (gaps allowed; addr/data hold last value).
//        After handshake with cnt==n-1 -> GAP. in_ready drops the cycle after the last accept.
//  GAP: exactly one cycle, ram_init=0 (last write completes before start).
//  START: start_sig=1 for exactly one cycle; arms done edge detector (registered done_in copy).
//  WAIT: on first rising edge of done_in seen after START (done_in=1, previous sample 0): res_data<=result_in,
//        res_err<=0, -> RESP. done_in already high at START is ignored until it falls and rises again.
//  RESP: res_valid=1, res_data/res_err stable until res_valid&res_ready; then -> IDLE. Not dropped while waiting.
//  Address width: cnt truncated to ADDR_W on a_addr_in/b_addr_in; DEPTH guarantees no wrap.
//  Throughput: one element per cycle in LOAD; cmd-to-first-write latency 2 cycles.
//  cmd_valid in non-IDLE states ignored (cmd_ready=0); in_valid outside LOAD ignored (in_ready=0).
// CONFIGURATION
//  DOT_TIMEOUT_EN defined: WAIT counts cycles from entry; reaching TIMEOUT_CYC without done edge -> RESP
//   with res_err=1, res_data=0. Counter cleared on each WAIT entry. A done edge in the same cycle as expiry wins.
//  DOT_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely until done edge or reset.
// TESTING
//  1 cmd_n=10, pairs a=b=i (i=0..9) back-to-back, model returns sum -> 10 ram_init pulses addr 0..9, one start_sig, res_data=285, res_err=0.
//  2 Same as 1 with in_valid toggling every other cycle and res_ready low 5 cycles -> identical writes/result; res_data held stable.
//  3 cmd_n=0 -> no ram_init, no start_sig, res_valid with res_data=0, res_err=0 within 2 cycles.
//  4 cmd_n=DEPTH+1 -> in_ready never high, res_err=1, res_data=0.
//  5 sys_rst asserted mid-LOAD at element 4 of 10 -> outputs 0 asynchronously; new cmd_n=3 (a=b=2) -> res_data=12.
//  6 DOT_TIMEOUT_EN, done_in held 0 -> res_err=1 exactly TIMEOUT_CYC cycles after WAIT entry; without macro busy stays 1.

Source files
------------

// File: rtl/dot_host_ctrl_if.sv
// dot_host_ctrl_if: host command / element stream / response channels plus the
// accelerator-facing RAM write, start and done signals of the dot-product engine.
// Ports: master = host fabric + accelerator side, slave = dot_host_ctrl.
interface dot_host_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    // host command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_n;
    // host element-pair stream
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    // accelerator RAM load / control / status
    logic              ram_init;
    logic [ADDR_W-1:0] a_addr_in;
    logic [ADDR_W-1:0] b_addr_in;
    logic [DATA_W-1:0] a_ram_in;
    logic [DATA_W-1:0] b_ram_in;
    logic              start_sig;
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] result_in;
    logic              done_in;
    // host response channel
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic              busy;

    modport master (
        output cmd_valid, cmd_n, in_valid, in_a, in_b, result_in, done_in, res_ready,
        input  cmd_ready, in_ready, ram_init, a_addr_in, b_addr_in, a_ram_in, b_ram_in,
               start_sig, n, res_valid, res_data, res_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_n, in_valid, in_a, in_b, result_in, done_in, res_ready,
        output cmd_ready, in_ready, ram_init, a_addr_in, b_addr_in, a_ram_in, b_ram_in,
               start_sig, n, res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/dot_host_ctrl.sv
// dot_host_ctrl: loads (a,b) pairs into the dot-product accelerator RAMs, pulses start, returns result.
// Latency: command accept to first RAM write 2 cycles; one element per cycle while loading.
// Backpressure: cmd_ready only in IDLE, in_ready only in LOAD; response held until res_ready.
// Ports: sys_clk, sys_rst (async, active-high), bus (dot_host_ctrl_if.slave: cmd/in/res channels
//        towards the host, ram_init/addr/data/start_sig/n/result_in/done_in towards the accelerator).
// Option: define DOT_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYC cycles.
module dot_host_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic             sys_clk,
    input logic             sys_rst,
    dot_host_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_START, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              ram_init_q, ram_init_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic              cmd_ready_q, in_ready_q, done_prev_q;
    logic              cmd_fire, in_fire, done_rise;

    // Ready flags are registered from the next state so they read 0 during reset
    // and come up one cycle after release.
    assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
    assign in_fire   = bus.in_valid & in_ready_q;
    // done_prev_q tracks done_in every cycle, so a level already high when
    // WAIT is entered never looks like a rising edge.
    assign done_rise = bus.done_in & ~done_prev_q;

`ifdef DOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        ram_init_d = 1'b0;
        addr_d     = addr_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
`ifdef DOT_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    n_d        = bus.cmd_n;
                    cnt_d      = '0;
                    res_data_d = '0;
                    res_err_d  = 1'b0;
                    if (bus.cmd_n == '0) begin
                        state_d = S_RESP;
                    end else if (bus.cmd_n > DATA_W'(DEPTH)) begin
                        res_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    ram_init_d = 1'b1;
                    addr_d     = cnt_q[ADDR_W-1:0];
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    cnt_d      = cnt_q + DATA_W'(1);
                    if (cnt_q == n_q - DATA_W'(1)) begin
                        state_d = S_GAP;
                    end
                end
            end
            // One idle cycle lets the final RAM write land before start.
            S_GAP: state_d = S_START;
            S_START: begin
                state_d = S_WAIT;
`ifdef DOT_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
`ifdef DOT_TIMEOUT_EN
                tmo_d = tmo_q + TW'(1);
`endif
                // A done edge takes priority over watchdog expiry in the same cycle.
                if (done_rise) begin
                    res_data_d = bus.result_in;
                    res_err_d  = 1'b0;
                    state_d    = S_RESP;
                end
`ifdef DOT_TIMEOUT_EN
                else if (tmo_hit) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            ram_init_q  <= 1'b0;
            addr_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            ram_init_q  <= ram_init_d;
            addr_q      <= addr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            cmd_ready_q <= (state_d == S_IDLE);
            in_ready_q  <= (state_d == S_LOAD);
            done_prev_q <= bus.done_in;
        end
    end

`ifdef DOT_TIMEOUT_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.ram_init  = ram_init_q;
    assign bus.a_addr_in = addr_q;
    assign bus.b_addr_in = addr_q;
    assign bus.a_ram_in  = a_q;
    assign bus.b_ram_in  = b_q;
    assign bus.start_sig = (state_q == S_START);
    assign bus.n         = n_q;
    assign bus.res_valid = (state_q == S_RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_dot_host_ctrl.sv
// tb_dot_host_ctrl: drives commands and element streams into dot_host_ctrl, plays the
// accelerator (RAM capture, delayed done pulse with computed dot product) and checks
// writes, start pulses and responses against expectations built from the input data.
module tb_dot_host_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;
    localparam int TMO   = 4096;
    localparam int WMAX  = 2048;

    logic sys_clk = 1'b0;
    logic sys_rst;

    dot_host_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dot_host_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- write / start recorder ----------------
    int             cyc_no = 0;
    int             wr_cnt = 0;
    int             start_cnt = 0;
    int             last_start_cyc = 0;
    int             addr_diff = 0;
    logic [AW-1:0]  wr_addr [WMAX];
    logic [DW-1:0]  wr_a    [WMAX];
    logic [DW-1:0]  wr_b    [WMAX];
    int             wr_cyc  [WMAX];

    always @(negedge sys_clk) begin
        cyc_no <= cyc_no + 1;
        if (bus.ram_init) begin
            if (wr_cnt < WMAX) begin
                wr_addr[wr_cnt] <= bus.a_addr_in;
                wr_a[wr_cnt]    <= bus.a_ram_in;
                wr_b[wr_cnt]    <= bus.b_ram_in;
                wr_cyc[wr_cnt]  <= cyc_no;
            end
            if (bus.a_addr_in !== bus.b_addr_in) addr_diff <= addr_diff + 1;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.start_sig) begin
            start_cnt      <= start_cnt + 1;
            last_start_cyc <= cyc_no;
        end
    end

    // ---------------- accelerator model ----------------
    logic [DW-1:0] acc_ram_a [65536];
    logic [DW-1:0] acc_ram_b [65536];
    bit acc_en     = 1'b1;
    bit acc_pre_hi = 1'b0;
    int acc_lat    = 3;
    int acc_t;
    bit acc_act;

    function automatic logic [DW-1:0] acc_dot();
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < int'(bus.n) && k < 65536; k++) s += acc_ram_a[k] * acc_ram_b[k];
        return s;
    endfunction

    always @(negedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc_act       <= 1'b0;
            acc_t         <= 0;
            bus.done_in   <= 1'b0;
            bus.result_in <= '0;
        end else begin
            if (bus.ram_init) begin
                acc_ram_a[bus.a_addr_in] <= bus.a_ram_in;
                acc_ram_b[bus.b_addr_in] <= bus.b_ram_in;
            end
            if (bus.start_sig) begin
                acc_act       <= acc_en;
                acc_t         <= 0;
                bus.result_in <= 32'hDEAD_BEEF;
            end else if (acc_act) begin
                acc_t <= acc_t + 1;
                if (acc_t == 2) bus.done_in <= 1'b0;
                if (acc_t == 2 + acc_lat) begin
                    bus.done_in   <= 1'b1;
                    bus.result_in <= acc_dot();
                end
                if (acc_t == 6 + acc_lat) begin
                    bus.done_in <= 1'b0;
                    acc_act     <= 1'b0;
                end
            end else begin
                bus.done_in <= acc_pre_hi;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dmode: 0 a=b=index, 1 a=b=2, 2 random. vmode: 0 back-to-back, 1 every other cycle, 2 random.
    // abort_at >= 0: assert reset after that many accepted pairs.
    task automatic run_cmd(input string tag, input int nn, input int dmode, input int vmode,
                           input int rdly, input bit want_tmo, input int abort_at);
        logic [DW-1:0] av [1024];
        logic [DW-1:0] bv [1024];
        logic [DW-1:0] exp_sum, held_d;
        logic          held_e;
        int            base, sbase, i, guard, t_acc, t_res, bad;
        bit            load_ok, hs, stable;

        load_ok = (nn > 0) && (nn <= DEPTH);
        exp_sum = '0;
        for (int k = 0; k < nn && k < 1024; k++) begin
            case (dmode)
                0:       begin av[k] = DW'(k); bv[k] = DW'(k); end
                1:       begin av[k] = 32'd2;  bv[k] = 32'd2;  end
                default: begin av[k] = $urandom; bv[k] = $urandom; end
            endcase
            exp_sum += av[k] * bv[k];
        end

        base  = wr_cnt;
        sbase = start_cnt;
        bus.cmd_n     = DW'(nn);
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        t_acc = cyc_no;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        check({tag, "_n_latched"}, bus.n, DW'(nn));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);

        if (load_ok) begin
            i = 0;
            guard = 0;
            while (i < nn && i != abort_at && guard < 20000) begin
                bus.in_a = av[i];
                bus.in_b = bv[i];
                case (vmode)
                    0:       bus.in_valid = 1'b1;
                    1:       bus.in_valid = (guard % 2 == 0);
                    default: bus.in_valid = 1'($urandom_range(0, 1));
                endcase
                hs = bus.in_valid && bus.in_ready;
                @(negedge sys_clk);
                if (hs) i++;
                guard++;
            end
            bus.in_valid = 1'b0;
            if (i == abort_at) begin
                check({tag, "_ram_init_pre"}, 32'(bus.ram_init), 32'd1);
                #2 sys_rst = 1'b1;
                #1;
                check({tag, "_rst_ram_init"},  32'(bus.ram_init),  32'd0);
                check({tag, "_rst_start"},     32'(bus.start_sig), 32'd0);
                check({tag, "_rst_busy"},      32'(bus.busy),      32'd0);
                check({tag, "_rst_in_ready"},  32'(bus.in_ready),  32'd0);
                check({tag, "_rst_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
                check({tag, "_rst_n"},         bus.n,              32'd0);
                @(negedge sys_clk);
                sys_rst = 1'b0;
                return;
            end
            check({tag, "_pairs_sent"}, i, nn);
            check({tag, "_in_ready_drop"}, 32'(bus.in_ready), 32'd0);
        end else begin
            check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
        end

        if (want_tmo) begin
`ifdef DOT_TIMEOUT_EN
            guard = 0;
            while (!bus.res_valid && guard < TMO + 100) begin
                @(negedge sys_clk);
                guard++;
            end
            t_res = cyc_no;
            check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
            check({tag, "_tmo_latency"}, 32'(t_res - last_start_cyc), 32'(TMO + 1));
            check({tag, "_res_err"}, 32'(bus.res_err), 32'd1);
            check({tag, "_res_data"}, bus.res_data, 32'd0);
            bus.res_ready = 1'b1;
            @(negedge sys_clk);
            bus.res_ready = 1'b0;
            check({tag, "_idle"}, 32'(bus.busy), 32'd0);
`else
            bad = 0;
            repeat (TMO + 100) begin
                @(negedge sys_clk);
                if (!bus.busy || bus.res_valid) bad++;
            end
            check({tag, "_wait_holds"}, bad, 32'd0);
            sys_rst = 1'b1;
            @(negedge sys_clk);
            sys_rst = 1'b0;
            @(negedge sys_clk);
            check({tag, "_busy_after_rst"}, 32'(bus.busy), 32'd0);
`endif
            check({tag, "_starts"}, start_cnt - sbase, 32'd1);
            return;
        end

        guard = 0;
        bad   = 0;
        while (!bus.res_valid && guard < 500) begin
            if (bus.in_ready) bad++;
            @(negedge sys_clk);
            guard++;
        end
        t_res = cyc_no;
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        if (nn == 0) check({tag, "_resp_latency_ok"}, 32'(t_res - t_acc <= 2), 32'd1);
        if (!load_ok) check({tag, "_in_ready_seen"}, bad, 32'd0);

        held_d = bus.res_data;
        held_e = bus.res_err;
        stable = 1'b1;
        repeat (rdly) begin
            @(negedge sys_clk);
            if (!bus.res_valid || bus.res_data !== held_d || bus.res_err !== held_e) stable = 1'b0;
        end
        if (rdly > 0) check({tag, "_res_stable"}, 32'(stable), 32'd1);
        check({tag, "_res_data"}, bus.res_data, load_ok ? exp_sum : 32'd0);
        check({tag, "_res_err"}, 32'(bus.res_err), 32'(nn > DEPTH));

        bus.res_ready = 1'b1;
        @(negedge sys_clk);
        bus.res_ready = 1'b0;
        check({tag, "_res_dropped"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);

        check({tag, "_writes"}, wr_cnt - base, load_ok ? nn : 0);
        bad = 0;
        for (int k = 0; k < nn && load_ok && base + k < WMAX; k++) begin
            if (wr_addr[base + k] !== AW'(k) || wr_a[base + k] !== av[k] || wr_b[base + k] !== bv[k]) bad++;
        end
        check({tag, "_write_content"}, bad, 32'd0);
        check({tag, "_starts"}, start_cnt - sbase, load_ok ? 32'd1 : 32'd0);
        if (vmode == 0 && load_ok && base < WMAX)
            check({tag, "_first_write_lat"}, 32'(wr_cyc[base] - t_acc), 32'd2);
    endtask

    initial begin
        sys_rst       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_n     = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_ram_init",  32'(bus.ram_init),  32'd0);
        check("rst_start",     32'(bus.start_sig), 32'd0);
        check("rst_n",         bus.n,              32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        run_cmd("t1_seq",      10,        0, 0, 0, 1'b0, -1);
        run_cmd("t2_gaps",     10,        0, 1, 5, 1'b0, -1);
        run_cmd("t3_zero",     0,         0, 0, 0, 1'b0, -1);
        run_cmd("t4_over",     DEPTH + 1, 0, 0, 0, 1'b0, -1);
        run_cmd("t5_abort",    10,        0, 0, 0, 1'b0, 4);
        run_cmd("t5_recover",  3,         1, 0, 0, 1'b0, -1);

        acc_pre_hi = 1'b1;
        run_cmd("t7_done_high", 6, 2, 0, 0, 1'b0, -1);
        acc_pre_hi = 1'b0;

        for (int r = 0; r < 8; r++) begin
            acc_lat = $urandom_range(1, 6);
            run_cmd("rnd", $urandom_range(1, 40), 2, 2, $urandom_range(0, 3), 1'b0, -1);
        end

        run_cmd("t8_full", DEPTH, 2, 2, 1, 1'b0, -1);

        acc_en = 1'b0;
        run_cmd("t6_timeout", 4, 2, 0, 0, 1'b1, -1);
        acc_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
